reg_bank_arbiter: RTL and testbench
===================================

# reg_bank_arbiter

Shares a small bank of D-flip-flop registers between two requesters. Each cycle it grants at most one read or write access, using round-robin priority plus an optional lock for back-to-back bursts. Writes take effect at the clock edge. Reads return registered data one cycle later. The block sits between two simple master ports and the flip-flop storage, so that the storage never sees two accesses in one cycle.

## Interface
- WIDTH, 8, data width of each register
- DEPTH, 4, number of registers (power of two)
- AW, log2(DEPTH) = 2, address width
- CLK  in  1  rising-edge clock, single clock domain
- RESET_L  in  1  asynchronous, active-low reset
- REQ0 / REQ1  in  1  access request from requester 0 / 1
- WE0 / WE1  in  1  1 = write, 0 = read
- ADDR0 / ADDR1  in  AW  register address
- WDATA0 / WDATA1  in  WIDTH  write data
- LOCK0 / LOCK1  in  1  keep ownership after this transfer
- GNT0 / GNT1  out  1  grant; transfer completes at the edge where REQx && GNTx
- RDATA  out  WIDTH  read data
- RVALID  out  1  RDATA valid this cycle
- RID  out  1  requester the read data belongs to
- BUSY  out  1  a lock is held (state is not FREE)

## Operation
- Requester handshake: hold REQx, WEx, ADDRx, WDATAx and LOCKx stable until the edge where GNTx=1. Dropping REQx before a grant is allowed and means no transfer.
- GNT0/GNT1 are combinational from the current state, the priority pointer PRI and the REQ inputs. They are never high together and are forced to 0 while RESET_L=0.
- FSM states: FREE, OWN0, OWN1.
- FREE state:
  - One requester active: grant it.
  - Both active: grant requester PRI.
  - A granted transfer with LOCKx=1 moves the FSM to OWNx.
- OWNx state:
  - Only x may be granted.
  - A granted transfer with LOCKx=0 returns the FSM to FREE.
  - REQx=0 also returns the FSM to FREE, with no grant in that cycle (one bubble).
- PRI update: when a transfer by x completes and the FSM goes (or stays) FREE, PRI becomes the other requester. PRI does not change during a locked burst.
- Write: reg[ADDRx] <= WDATAx at the grant edge. There is only one grant per cycle, so there is no write conflict.
- Read: RDATA <= reg[ADDRx], RID <= x and RVALID <= 1 at the grant edge. Otherwise RVALID <= 0 and RDATA/RID hold their values.
- Read-after-write: a read granted the cycle after a write to the same address returns the new data.
- Addresses are exactly AW bits. Every value from 0 to DEPTH-1 is valid, so there is no out-of-range case.

## Timing
- Reset values (asynchronous, immediate): all registers 0, state FREE, PRI=0, RDATA=0, RVALID=0, RID=0, BUSY=0, GNT0=GNT1=0.
- Reset asserted mid-burst: the lock is lost and the interrupted transfer is not performed.
- Reset released: the first rising edge with RESET_L=1 may complete a transfer.
- Write latency: the data is visible in storage after 1 edge.
- Read latency: RVALID rises in the cycle after the grant edge and lasts exactly 1 cycle per read.
- Arbitration latency: grant is in the same cycle when uncontended.
- Fairness: with both requesters continuously active and unlocked, grants alternate every cycle.
- Worst-case wait for an unlocked contender is 1 cycle, plus the length of any lock held by the other requester.
- BUSY equals (state != FREE) and is registered.

## Structure
- Shared package `reg_bank_pkg`:
  - state encoding: FREE=2'b00, OWN0=2'b01, OWN1=2'b10
  - requester IDs: ID0=1'b0, ID1=1'b1
  - default WIDTH and DEPTH constants
- Sub-module `reg_bank`:
  - DEPTH x WIDTH flip-flop storage with a write port and an asynchronous read mux
  - asynchronous active-low clear
- The top level holds the FSM, the PRI register, the grant logic, the request mux and the read-data output register.

## Test plan
- Reset: pulse RESET_L low in the middle of a locked burst by requester 0 -> all outputs 0 immediately; a subsequent read of address 2 returns RDATA=0x00.
- Single requester: requester 0 writes 0xA5 to address 1, then reads address 1 -> GNT0 in each request cycle; RVALID=1, RDATA=0xA5, RID=0 in the cycle after the read grant.
- Contention after reset: both requesters issue unlocked reads continuously -> the grant sequence is GNT0, GNT1, GNT0, GNT1; RID alternates 0, 1, 0, 1, each one cycle after its grant.
- Lock burst: requester 0 writes addresses 0, 1, 2 with LOCK0=1, 1, 0 while REQ1 is held high -> BUSY=1 during the burst; GNT1=0 for 3 cycles; GNT1=1 in the 4th cycle.
- Lock abandoned: requester 1 locks and then drops REQ1 while REQ0 is high -> one cycle with no grant; FSM returns to FREE; GNT0 in the next cycle.
- Address boundary: write 0x3C to address 3 and 0xC3 to address 0, then read both -> RDATA is 0x3C then 0xC3, with no aliasing.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared constants for the two-port arbitrated register bank: FSM encoding,
// requester IDs and default geometry.
package reg_bank_pkg;

  localparam logic [1:0] FREE = 2'b00;
  localparam logic [1:0] OWN0 = 2'b01;
  localparam logic [1:0] OWN1 = 2'b10;

  localparam logic ID0 = 1'b0;
  localparam logic ID1 = 1'b1;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 4;

endpackage

// File: rtl/reg_bank.sv
// DEPTH x WIDTH flip-flop storage with a single write port, an asynchronous
// read mux and an asynchronous active-low clear.
module reg_bank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/reg_bank_arbiter.sv
// Two-requester arbiter in front of a flip-flop register bank: round-robin
// priority, optional lock for bursts, one access per cycle, registered read data.
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [AW-1:0]    addr0,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  input  logic             lock0,
  input  logic             lock1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             rid,
  output logic             busy
);

  logic [1:0]       state_q, state_d;
  logic             pri_q, pri_d;
  logic             busy_q;
  logic [WIDTH-1:0] rdata_q;
  logic             rvalid_q;
  logic             rid_q;

  logic             gnt0_raw, gnt1_raw;
  logic             xfer;
  logic             sel_id;
  logic             sel_we;
  logic             sel_lock;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_wdata;
  logic [WIDTH-1:0] bank_rdata;

  always_comb begin
    gnt0_raw = 1'b0;
    gnt1_raw = 1'b0;
    case (state_q)
      FREE: begin
        if (req0 && req1) begin
          gnt0_raw = (pri_q == ID0);
          gnt1_raw = (pri_q == ID1);
        end else begin
          gnt0_raw = req0;
          gnt1_raw = req1;
        end
      end
      OWN0:    gnt0_raw = req0;
      OWN1:    gnt1_raw = req1;
      default: ;
    endcase
  end

  // Grants are masked by reset so nothing is offered while the bank is being cleared.
  assign gnt0 = gnt0_raw & reset_l;
  assign gnt1 = gnt1_raw & reset_l;
  assign xfer = gnt0 | gnt1;

  assign sel_id    = gnt1 ? ID1 : ID0;
  assign sel_we    = gnt1 ? we1 : we0;
  assign sel_lock  = gnt1 ? lock1 : lock0;
  assign sel_addr  = gnt1 ? addr1 : addr0;
  assign sel_wdata = gnt1 ? wdata1 : wdata0;

  always_comb begin
    state_d = state_q;
    pri_d   = pri_q;
    case (state_q)
      FREE: begin
        if (xfer) begin
          if (sel_lock) begin
            state_d = (sel_id == ID1) ? OWN1 : OWN0;
          end else begin
            pri_d = ~sel_id;
          end
        end
      end
      OWN0: begin
        // Dropping the request abandons the lock without a transfer.
        if (!req0) begin
          state_d = FREE;
        end else if (!lock0) begin
          state_d = FREE;
          pri_d   = ID1;
        end
      end
      OWN1: begin
        if (!req1) begin
          state_d = FREE;
        end else if (!lock1) begin
          state_d = FREE;
          pri_d   = ID0;
        end
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q  <= FREE;
      pri_q    <= ID0;
      busy_q   <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rid_q    <= ID0;
    end else begin
      state_q  <= state_d;
      pri_q    <= pri_d;
      busy_q   <= (state_d != FREE);
      rvalid_q <= xfer & ~sel_we;
      if (xfer && !sel_we) begin
        rdata_q <= bank_rdata;
        rid_q   <= sel_id;
      end
    end
  end

  reg_bank #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_reg_bank (
    .clk     (clk),
    .reset_l (reset_l),
    .we      (xfer & sel_we),
    .addr    (sel_addr),
    .wdata   (sel_wdata),
    .rdata   (bank_rdata)
  );

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign rid    = rid_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed self-checking bench for reg_bank_arbiter: inputs change on the
// falling edge, grants are sampled 1 ns later, registered outputs on the next falling edge.
module tb_reg_bank_arbiter;

  logic       clk = 1'b0;
  logic       reset_l;
  logic       req0, req1, we0, we1, lock0, lock1;
  logic [1:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid, rid, busy;
  logic [7:0] rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_bank_arbiter #(
    .WIDTH (8),
    .DEPTH (4),
    .AW    (2)
  ) dut (
    .clk     (clk),
    .reset_l (reset_l),
    .req0    (req0),
    .req1    (req1),
    .we0     (we0),
    .we1     (we1),
    .addr0   (addr0),
    .addr1   (addr1),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .lock0   (lock0),
    .lock1   (lock1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .rid     (rid),
    .busy    (busy)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
  endtask

  task automatic test_reset();
    reset_l = 0;
    idle_inputs();
    req0 = 1; req1 = 1;
    #1;
    checks++;
    if ({gnt0, gnt1, busy, rvalid, rid} !== 5'b0 || rdata !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: gnt0=%b gnt1=%b busy=%b rvalid=%b rid=%b rdata=%h want all 0",
               gnt0, gnt1, busy, rvalid, rid, rdata);
    end
    @(negedge clk);
    idle_inputs();
    reset_l = 1;
  endtask

  task automatic test_single();
    req0 = 1; we0 = 1; addr0 = 1; wdata0 = 8'hA5;
    #1;
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      failures++;
      $display("FAIL single_wr_gnt: gnt0=%b gnt1=%b want 1 0", gnt0, gnt1);
    end
    step();
    we0 = 0;
    #1;
    checks++;
    if (gnt0 !== 1'b1 || rvalid !== 1'b0) begin
      failures++;
      $display("FAIL single_rd_gnt: gnt0=%b rvalid=%b want 1 0", gnt0, rvalid);
    end
    step();
    req0 = 0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 8'hA5 || rid !== 1'b0) begin
      failures++;
      $display("FAIL single_rdata: rvalid=%b rdata=%h rid=%b want 1 a5 0", rvalid, rdata, rid);
    end
    step();
    checks++;
    if (rvalid !== 1'b0) begin
      failures++;
      $display("FAIL single_rvalid_pulse: rvalid=%b want 0", rvalid);
    end
  endtask

  task automatic test_contention();
    reset_l = 0;
    #2;
    reset_l = 1;
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 0; addr1 = 3;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1)) begin
        failures++;
        $display("FAIL contention_gnt[%0d]: gnt0=%b gnt1=%b want %b %b",
                 i, gnt0, gnt1, (i % 2 == 0), (i % 2 == 1));
      end
      step();
      checks++;
      if (rvalid !== 1'b1 || rid !== (i % 2 == 1) || rdata !== 8'h00) begin
        failures++;
        $display("FAIL contention_rid[%0d]: rvalid=%b rid=%b rdata=%h want 1 %b 00",
                 i, rvalid, rid, rdata, (i % 2 == 1));
      end
    end
    idle_inputs();
  endtask

  task automatic test_lock_burst();
    logic [7:0] data [3];
    logic       lk [3];
    data[0] = 8'h10; data[1] = 8'h11; data[2] = 8'h12;
    lk[0] = 1; lk[1] = 1; lk[2] = 0;
    req1 = 1; we1 = 0; addr1 = 0; lock1 = 0;
    req0 = 1; we0 = 1;
    for (int i = 0; i < 3; i++) begin
      addr0 = 2'(i); wdata0 = data[i]; lock0 = lk[i];
      #1;
      checks++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || busy !== (i != 0)) begin
        failures++;
        $display("FAIL lock_burst[%0d]: gnt0=%b gnt1=%b busy=%b want 1 0 %b",
                 i, gnt0, gnt1, busy, (i != 0));
      end
      step();
    end
    req0 = 0; lock0 = 0; we0 = 0;
    #1;
    checks++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL lock_release: gnt1=%b gnt0=%b busy=%b want 1 0 0", gnt1, gnt0, busy);
    end
    step();
    req1 = 0;
    checks++;
    if (rvalid !== 1'b1 || rid !== 1'b1 || rdata !== 8'h10) begin
      failures++;
      $display("FAIL lock_readback: rvalid=%b rid=%b rdata=%h want 1 1 10", rvalid, rid, rdata);
    end
    idle_inputs();
  endtask

  task automatic test_lock_abandon();
    req1 = 1; we1 = 1; addr1 = 3; wdata1 = 8'h55; lock1 = 1;
    #1;
    checks++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
      failures++;
      $display("FAIL abandon_lock_gnt: gnt1=%b gnt0=%b want 1 0", gnt1, gnt0);
    end
    step();
    req1 = 0; lock1 = 0;
    req0 = 1; we0 = 0; addr0 = 3; lock0 = 0;
    #1;
    checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL abandon_bubble: gnt0=%b gnt1=%b busy=%b want 0 0 1", gnt0, gnt1, busy);
    end
    step();
    #1;
    checks++;
    if (gnt0 !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abandon_free: gnt0=%b busy=%b want 1 0", gnt0, busy);
    end
    step();
    req0 = 0;
    checks++;
    if (rvalid !== 1'b1 || rid !== 1'b0 || rdata !== 8'h55) begin
      failures++;
      $display("FAIL abandon_readback: rvalid=%b rid=%b rdata=%h want 1 0 55", rvalid, rid, rdata);
    end
    idle_inputs();
  endtask

  task automatic test_addr_boundary();
    req0 = 1; we0 = 1; addr0 = 3; wdata0 = 8'h3C;
    step();
    addr0 = 0; wdata0 = 8'hC3;
    step();
    we0 = 0; addr0 = 3;
    step();
    addr0 = 0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 8'h3C) begin
      failures++;
      $display("FAIL boundary_addr3: rvalid=%b rdata=%h want 1 3c", rvalid, rdata);
    end
    step();
    req0 = 0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 8'hC3) begin
      failures++;
      $display("FAIL boundary_addr0: rvalid=%b rdata=%h want 1 c3", rvalid, rdata);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    req0 = 1; we0 = 1; addr0 = 2; wdata0 = 8'h77; lock0 = 1;
    step();
    addr0 = 1; wdata0 = 8'h99;
    #1;
    checks++;
    if (busy !== 1'b1 || gnt0 !== 1'b1) begin
      failures++;
      $display("FAIL midburst_locked: busy=%b gnt0=%b want 1 1", busy, gnt0);
    end
    reset_l = 0;
    #1;
    checks++;
    if ({gnt0, gnt1, busy, rvalid, rid} !== 5'b0 || rdata !== 8'h00) begin
      failures++;
      $display("FAIL midburst_reset: gnt0=%b gnt1=%b busy=%b rvalid=%b rid=%b rdata=%h want 0",
               gnt0, gnt1, busy, rvalid, rid, rdata);
    end
    @(negedge clk);
    reset_l = 1;
    we0 = 0; addr0 = 2; lock0 = 0;
    step();
    addr0 = 1;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 8'h00) begin
      failures++;
      $display("FAIL midburst_rd_addr2: rvalid=%b rdata=%h want 1 00", rvalid, rdata);
    end
    step();
    req0 = 0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 8'h00) begin
      failures++;
      $display("FAIL midburst_rd_addr1: rvalid=%b rdata=%h want 1 00", rvalid, rdata);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_lock_burst();
    test_lock_abandon();
    test_addr_boundary();
    test_reset_mid_burst();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
